// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline interlock: mul/div FSM encodings,
// the $0 register constant, forwarding mux-select encodings and a helper.
package hazard_unit_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned MD_CNT_W = 6;

  localparam logic [REG_W-1:0] REG_ZERO = REG_W'(0);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_t;

  // Operand-forwarding mux selects used by the datapath next to this unit
  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  function automatic logic src_match(input logic             used,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
    return used & (src == dst);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-interlock bundle: ID/EX hazard sources in, stall/flush controls out.
interface hazard_unit_if
  import hazard_unit_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic [REG_W-1:0] rsID;
  logic [REG_W-1:0] rtID;
  logic             useRsID;
  logic             useRtID;
  logic             hiloRdID;
  logic [REG_W-1:0] rdEX;
  logic             GPRWrEX;
  logic             lwEX;
  logic             mdStartEX;
  logic             branchEX;
  logic             PCWr;
  logic             IRWr;
  logic             flushID;
  logic             flushEX;
  logic             mdBusy;
  logic [CNT_W-1:0] stallCnt;

  modport master (
    output rsID, rtID, useRsID, useRtID, hiloRdID,
    output rdEX, GPRWrEX, lwEX, mdStartEX, branchEX,
    input  PCWr, IRWr, flushID, flushEX, mdBusy, stallCnt
  );

  modport slave (
    input  rsID, rtID, useRsID, useRtID, hiloRdID,
    input  rdEX, GPRWrEX, lwEX, mdStartEX, branchEX,
    output PCWr, IRWr, flushID, flushEX, mdBusy, stallCnt
  );

endinterface

// File: rtl/hazard_unit_md_busy_ctr.sv
// Mul/div occupancy tracker: busy for MD_LAT cycles after each start.
module md_busy_ctr
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MD_LAT = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic md_start,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] LAT_LOAD = MD_CNT_W'(MD_LAT);
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

  md_state_t           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start while running reloads the full latency
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d = MD_RUN;
          cnt_d   = LAT_LOAD;
        end
      end
      MD_RUN: begin
        if (md_start) begin
          cnt_d = LAT_LOAD;
        end else if (cnt_q == CNT_ONE) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy = (state_q == MD_RUN);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline interlock: load-use and HI/LO stalls, taken-branch squash,
// and a saturating stall-cycle counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_unit_if.slave  hif
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             md_busy;
  logic             load_use_c;
  logic             md_haz_c;
  logic             stall_c;
  logic             flush_c;
  logic [CNT_W-1:0] stall_cnt_q;

  md_busy_ctr #(
    .MD_LAT (MD_LAT)
  ) u_md_busy_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .md_start (hif.mdStartEX),
    .md_busy  (md_busy)
  );

  // Hazard decode; reset forces the free-running (no stall, no flush) controls
  always_comb begin
    load_use_c = hif.lwEX & hif.GPRWrEX & (hif.rdEX != REG_ZERO) &
                 (src_match(hif.useRsID, hif.rsID, hif.rdEX) |
                  src_match(hif.useRtID, hif.rtID, hif.rdEX));
    md_haz_c   = hif.hiloRdID & (md_busy | hif.mdStartEX);
    flush_c    = rst_n & hif.branchEX;
    stall_c    = rst_n & ~hif.branchEX & (load_use_c | md_haz_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_ONE;
    end
  end

  assign hif.PCWr     = ~stall_c;
  assign hif.IRWr     = ~stall_c;
  assign hif.flushID  = flush_c;
  assign hif.flushEX  = flush_c | stall_c;
  assign hif.mdBusy   = md_busy;
  assign hif.stallCnt = stall_cnt_q;

endmodule
